// File: rtl/oled_pkg.sv
// Shared OLED definitions: panel geometry, RGB565 palette used by the screen
// renderers, and the frame streamer state encoding.
package oled_pkg;

  localparam int unsigned OLED_WIDTH  = 96;
  localparam int unsigned OLED_HEIGHT = 64;
  localparam int unsigned PIX_W       = 16;

  localparam logic [PIX_W-1:0] WHITE      = 16'hFFFF;
  localparam logic [PIX_W-1:0] BLACK      = 16'h0000;
  localparam logic [PIX_W-1:0] RED        = 16'hF800;
  localparam logic [PIX_W-1:0] GREEN      = 16'h07E0;
  localparam logic [PIX_W-1:0] BLUE       = 16'h001F;
  localparam logic [PIX_W-1:0] LIGHTGREEN = 16'h87F0;
  localparam logic [PIX_W-1:0] DARKGREEN  = 16'h03E0;
  localparam logic [PIX_W-1:0] YELLOW     = 16'hFFE0;
  localparam logic [PIX_W-1:0] CYAN       = 16'h07FF;
  localparam logic [PIX_W-1:0] MAGENTA    = 16'hF81F;

  typedef enum logic [2:0] {IDLE, SETUP, LOAD, SHIFT, HOLD} state_t;

endpackage

// File: rtl/oled_spi_shifter.sv
// MSB-first SPI mode-3 word serialiser: each bit is CLK_DIV cycles of sclk low
// followed by CLK_DIV cycles of sclk high; done flags the final high cycle.
module oled_spi_shifter
  import oled_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [PIX_W-1:0] word,
  output logic             sclk,
  output logic             mosi,
  output logic             done
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic             active_q;
  logic             high_q;
  logic [DW-1:0]    div_q;
  logic [3:0]       bit_q;
  logic [PIX_W-1:0] shreg_q;

  assign done = active_q && high_q && (bit_q == 4'd0) && (div_q == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      high_q   <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      sclk     <= 1'b1;
      mosi     <= 1'b0;
    end else if (load) begin
      // first bit's low phase starts on the capture edge itself
      active_q <= 1'b1;
      high_q   <= 1'b0;
      div_q    <= '0;
      bit_q    <= 4'd15;
      shreg_q  <= word;
      sclk     <= 1'b0;
      mosi     <= word[PIX_W-1];
    end else if (active_q) begin
      if (div_q == DIV_LAST) begin
        div_q <= '0;
        if (!high_q) begin
          high_q <= 1'b1;
          sclk   <= 1'b1;
        end else if (bit_q == 4'd0) begin
          active_q <= 1'b0;
        end else begin
          bit_q   <= bit_q - 4'd1;
          shreg_q <= shreg_q << 1;
          mosi    <= shreg_q[PIX_W-2];
          high_q  <= 1'b0;
          sclk    <= 1'b0;
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/oled_frame_streamer.sv
// Raster scanner for the 96x64 OLED: walks (x, y), captures the renderer's
// RGB565 pixel and streams one full frame over SPI per frame_req.
module oled_frame_streamer
  import oled_pkg::*;
#(
  parameter int unsigned WIDTH   = OLED_WIDTH,
  parameter int unsigned HEIGHT  = OLED_HEIGHT,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_req,
  output logic [6:0]       x,
  output logic [5:0]       y,
  input  logic [PIX_W-1:0] oled_data,
  output logic             busy,
  output logic             frame_done,
  output logic             spi_cs_n,
  output logic             spi_sclk,
  output logic             spi_mosi,
  output logic             spi_dc
);

  localparam int unsigned XW = (WIDTH > 1)   ? $clog2(WIDTH)   : 1;
  localparam int unsigned YW = (HEIGHT > 1)  ? $clog2(HEIGHT)  : 1;
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);
  localparam logic [DW-1:0] CNT_LAST = DW'(CLK_DIV - 1);

  state_t        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          busy_d, done_d, cs_n_d, dc_d;
  logic          load, shift_done;

  oled_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .word  (oled_data),
    .sclk  (spi_sclk),
    .mosi  (spi_mosi),
    .done  (shift_done)
  );

  assign x = 7'(x_q);
  assign y = 6'(y_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      spi_cs_n   <= 1'b1;
      spi_dc     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      busy       <= busy_d;
      frame_done <= done_d;
      spi_cs_n   <= cs_n_d;
      spi_dc     <= dc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    busy_d  = busy;
    done_d  = 1'b0;
    cs_n_d  = spi_cs_n;
    dc_d    = spi_dc;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_req) begin
          state_d = SETUP;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          dc_d    = 1'b1;
          x_d     = '0;
          y_d     = '0;
          cnt_d   = '0;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOAD: begin
        load    = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        // coordinates advance together with the LOAD entry so the renderer
        // sees the new (x, y) for the whole LOAD cycle
        if (shift_done) begin
          if (x_q == X_LAST && y_q == Y_LAST) begin
            state_d = HOLD;
            cs_n_d  = 1'b1;
            dc_d    = 1'b0;
          end else begin
            state_d = LOAD;
            if (x_q == X_LAST) begin
              x_d = '0;
              y_d = y_q + 1'b1;
            end else begin
              x_d = x_q + 1'b1;
            end
          end
        end
      end
      HOLD: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          x_d     = '0;
          y_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Directed bench for oled_frame_streamer on a 4x2 panel with CLK_DIV=1; a
// negedge monitor decodes SPI words and measures chip-select timing.
module tb_oled_frame_streamer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_req = 1'b0;
  logic [6:0]  x;
  logic [5:0]  y;
  logic [15:0] oled_data;
  logic        busy, frame_done, spi_cs_n, spi_sclk, spi_mosi, spi_dc;

  logic        toggle_en = 1'b0;
  logic        tog = 1'b0;
  logic [15:0] base_pix;

  int n_pass = 0;
  int n_total = 0;

  oled_frame_streamer #(.WIDTH(4), .HEIGHT(2), .CLK_DIV(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_req  (frame_req),
    .x          (x),
    .y          (y),
    .oled_data  (oled_data),
    .busy       (busy),
    .frame_done (frame_done),
    .spi_cs_n   (spi_cs_n),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_dc     (spi_dc)
  );

  always #5 clk = ~clk;

  // renderer model; optionally inverts its output every cycle
  always @(posedge clk) tog <= ~tog;
  assign base_pix  = {x[3:0], y[3:0], 8'hA5};
  assign oled_data = (toggle_en && tog) ? ~base_pix : base_pix;

  // SPI monitor
  logic        prev_sclk = 1'b1, prev_mosi = 1'b0, prev_cs = 1'b1;
  logic [15:0] prev_data = '0, cur = '0;
  logic [15:0] words[$];
  logic [15:0] loadv[$];
  int bitc = 0, rise_cnt = 0, viol = 0, done_cnt = 0, cyc = 0;
  int cs_low = 0, cs_len = 0, cs_high = 0, cs_gap = 0, cs_rise_cyc = 0, done_gap = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      bitc = 0;
    end else begin
      if (!spi_cs_n) begin
        if (prev_cs) begin cs_gap = cs_high; cs_low = 0; end
        cs_low++;
      end else begin
        if (!prev_cs) begin cs_len = cs_low; cs_rise_cyc = cyc; cs_high = 0; end
        cs_high++;
      end
      if (spi_mosi !== prev_mosi && !(prev_sclk && !spi_sclk)) viol++;
      if (prev_sclk && !spi_sclk && bitc == 0) loadv.push_back(prev_data);
      if (spi_sclk && !prev_sclk) begin
        rise_cnt++;
        cur = {cur[14:0], spi_mosi};
        bitc++;
        if (bitc == 16) begin words.push_back(cur); bitc = 0; end
      end
      if (frame_done) begin done_cnt++; done_gap = cyc - cs_rise_cyc; end
    end
    prev_sclk = spi_sclk;
    prev_mosi = spi_mosi;
    prev_cs   = spi_cs_n;
    prev_data = oled_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic wait_done(input string tag, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] tbl [8];
    int wb, rb, db, lb, seen;
    tbl = '{16'h00A5, 16'h10A5, 16'h20A5, 16'h30A5,
            16'h01A5, 16'h11A5, 16'h21A5, 16'h31A5};

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_sclk", spi_sclk, 1);
    check("rst_mosi", spi_mosi, 0);
    check("rst_dc", spi_dc, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_xy", {x, y}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("idle_no_sclk", rise_cnt, 0);
    check("idle_cs_n", spi_cs_n, 1);

    // single frame, with an extra request mid-frame that must be ignored
    wb = words.size(); rb = rise_cnt; db = done_cnt; lb = viol;
    @(negedge clk); frame_req = 1'b1;
    @(negedge clk); frame_req = 1'b0;
    #1;
    check("start_busy", busy, 1);
    check("start_cs_n", spi_cs_n, 0);
    check("start_dc", spi_dc, 1);
    check("start_xy", {x, y}, 0);
    repeat (50) @(negedge clk);
    frame_req = 1'b1;
    @(negedge clk); frame_req = 1'b0;
    wait_done("f1", 400);
    repeat (10) @(negedge clk);
    #1;
    check("f1_nwords", words.size() - wb, 8);
    for (int p = 0; p < 8; p++) check($sformatf("f1_word%0d", p), words[wb + p], tbl[p]);
    check("f1_first_bit_x3y0", {31'd0, words[wb + 3][15]}, 0);
    check("f1_cs_len", cs_len, 265);
    check("f1_done_cnt", done_cnt - db, 1);
    check("f1_done_gap", done_gap, 1);
    check("f1_rises", rise_cnt - rb, 128);
    check("f1_mosi_on_fall", viol - lb, 0);
    check("f1_idle", {busy, spi_cs_n, spi_dc, x, y}, {1'b0, 1'b1, 1'b0, 13'd0});

    // reset during SHIFT of the first pixel
    db = done_cnt;
    @(negedge clk); frame_req = 1'b1;
    @(negedge clk); frame_req = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_rst_cs_low", spi_cs_n, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cs_n", spi_cs_n, 1);
    check("mid_rst_sclk", spi_sclk, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_xy", {x, y}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rb = rise_cnt;
    repeat (10) @(negedge clk);
    #1;
    check("post_rst_no_sclk", rise_cnt - rb, 0);
    check("post_rst_cs_n", spi_cs_n, 1);
    check("post_rst_no_done", done_cnt - db, 0);

    // frame_req held high: two back-to-back frames
    wb = words.size(); db = done_cnt; lb = viol;
    @(negedge clk); frame_req = 1'b1;
    seen = 0;
    for (int i = 0; i < 1200 && seen < 2; i++) begin
      @(negedge clk);
      if (frame_done) seen++;
    end
    frame_req = 1'b0;
    check("b2b_two_done_seen", seen, 2);
    repeat (5) @(negedge clk);
    #1;
    check("b2b_done_cnt", done_cnt - db, 2);
    check("b2b_nwords", words.size() - wb, 16);
    for (int p = 0; p < 16; p++) check($sformatf("b2b_word%0d", p), words[wb + p], tbl[p % 8]);
    check("b2b_cs_gap", cs_gap, 2);
    check("b2b_mosi_on_fall", viol - lb, 0);

    // renderer output toggling every cycle: the LOAD-cycle value is sent
    wb = words.size(); lb = loadv.size();
    toggle_en = 1'b1;
    @(negedge clk); frame_req = 1'b1;
    @(negedge clk); frame_req = 1'b0;
    wait_done("tog", 400);
    toggle_en = 1'b0;
    check("tog_nwords", words.size() - wb, 8);
    for (int p = 0; p < 8; p++) begin
      check($sformatf("tog_word%0d", p), words[wb + p], loadv[lb + p]);
      check($sformatf("tog_valid%0d", p),
            {31'd0, (words[wb + p] == tbl[p]) || (words[wb + p] == ~tbl[p])}, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/oled_frame_streamer.md
Name: oled_frame_streamer

Overview:
- Consumer end of the pixel interface used by every screen renderer: produces raster coordinates (x, y), samples the renderer's combinational 16-bit RGB565 `oled_data`, and serialises each pixel MSB-first over a write-only SPI link to the 96x64 OLED panel.
- Sits between the active screen mux and the panel pins.
- One `frame_req` pulse streams one full frame.

Parameters:
- WIDTH, 96, pixels per row; x range 0..WIDTH-1
- HEIGHT, 64, rows per frame; y range 0..HEIGHT-1
- CLK_DIV, 2, clk cycles per SCLK half-period; must be ≥1

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- frame_req  in  1  start-frame request, sampled only in IDLE
- x  out  7  current pixel column to renderer
- y  out  6  current pixel row to renderer
- oled_data  in  16  RGB565 pixel from renderer for current (x, y)
- busy  out  1  high from frame accept until frame_done
- frame_done  out  1  one-cycle pulse at frame end
- spi_cs_n  out  1  panel chip select, active low
- spi_sclk  out  1  SPI clock, mode 3 (idles high, panel samples on rising edge)
- spi_mosi  out  1  serial data
- spi_dc  out  1  data/command select; 1 = pixel data

Behaviour:
- Reset (async assert, sync release): state IDLE, x=0, y=0, busy=0, frame_done=0, spi_cs_n=1, spi_sclk=1, spi_mosi=0, spi_dc=0. Reset mid-frame aborts immediately; no partial pixel is completed.
- States:
  - IDLE: frame_req=1 at edge t → SETUP at t+1. At t+1: busy=1, spi_cs_n=0, spi_dc=1, x=0, y=0.
  - SETUP: CLK_DIV cycles, cs_n low, sclk high → LOAD.
  - LOAD: 1 cycle. x, y have been stable since entry. At this cycle's end edge, oled_data is captured into a 16-bit shift register and the bit counter is set to 15 → SHIFT.
  - SHIFT: 16 bits, each 2*CLK_DIV cycles.
    - Each bit starts with sclk=0 and mosi=shreg[15] set on the same edge; held for CLK_DIV cycles.
    - Then sclk=1 for CLK_DIV cycles; the panel samples on this rising edge.
    - After the high phase of bit 0: if (x,y) = (WIDTH-1, HEIGHT-1) → HOLD. Else advance and → LOAD: x+1; at x=WIDTH-1, x=0 and y+1.
  - HOLD: spi_cs_n=1 and spi_dc=0 on entry; sclk=1; lasts CLK_DIV cycles. On exit: frame_done=1 for exactly 1 cycle, busy=0, x=0, y=0 → IDLE.
- Timing:
  - Per pixel: 1 + 32*CLK_DIV cycles.
  - cs_n low duration: CLK_DIV + WIDTH*HEIGHT*(1+32*CLK_DIV) cycles. Defaults give 2 + 6144*65 = 399362.
- frame_req while busy: ignored, not queued.
- frame_req held high continuously: back-to-back frames with one IDLE cycle between them.
- x, y change only on the LOAD-entry transition, so the renderer has at least 1 full cycle of settle time.
- oled_data changes during SHIFT have no effect on the pixel being sent.
- sclk toggles only in SHIFT. mosi is don't-care outside SHIFT but is held at its last value.
- Counters sized to $clog2 of the needed ranges. x/y wrap exactly at WIDTH-1/HEIGHT-1, never at the counter width.

Decomposition:
- Shared package `oled_pkg`:
  - OLED_WIDTH=96, OLED_HEIGHT=64, PIX_W=16
  - RGB565 colour constants: WHITE, BLACK, RED, GREEN, BLUE, LIGHTGREEN, DARKGREEN, etc., shared with all screen renderers
  - State enum {IDLE, SETUP, LOAD, SHIFT, HOLD}
- One sub-module: `oled_spi_shifter`.
  - Inputs: load, 16-bit word, CLK_DIV.
  - Outputs: sclk, mosi, done pulse.
  - The streamer FSM owns coordinates, cs_n, dc, busy and frame_done.

Test Plan:
- Bench parameters WIDTH=4, HEIGHT=2, CLK_DIV=1; renderer model returns {x[3:0], y[3:0], 8'hA5}.
- Reset mid-SHIFT (deassert rst_n for 3 cycles) → same cycle: cs_n=1, sclk=1, busy=0, x=0, y=0. After release, no SPI activity until frame_req.
- Single frame_req pulse → cs_n low for exactly 1 + 8*33 = 265 cycles. Decoded words in order: 0x00A5, 0x10A5, 0x20A5, 0x30A5, 0x01A5, 0x11A5, 0x21A5, 0x31A5. frame_done pulses once, 1 cycle after cs_n rises plus CLK_DIV.
- Bit timing → every mosi change coincides with a sclk falling edge. Exactly 16 rising edges per pixel. MSB first: first bit of pixel (3,0) is 0.
- frame_req pulsed again mid-frame → ignored; exactly 8 words sent, one frame_done.
- frame_req held high for 2 frames → two frames, one IDLE cycle between HOLD exit and SETUP, x/y restart at (0,0).
- Renderer output toggled every cycle during SHIFT → transmitted word equals the value present on the LOAD cycle.
